// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature synchronizer, glitch filter and x4 step decoder
module quad_step_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter logic [3:0] HOME_VALUE  = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       index,
    input  logic       dec_en,
    output logic       enable,
    output logic       up_down,
    output logic       set,
    output logic [3:0] set_value,
    output logic       error
);
    localparam int NUM_IN       = 3;
    localparam int PRIME_CYCLES = SYNC_STAGES + FILTER_LEN;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);
    localparam logic [PW-1:0] PRIME_LAST  = PW'(PRIME_CYCLES - 1);
    localparam logic [3:0]    FILTER_LAST = 4'(FILTER_LEN - 1);

    // Bit 0 = phase A, bit 1 = phase B, bit 2 = index.
    logic [NUM_IN-1:0]      raw;
    logic [SYNC_STAGES-1:0] sync_q [NUM_IN];
    logic [NUM_IN-1:0]      synced;
    logic [NUM_IN-1:0]      filt;
    logic [NUM_IN-1:0]      filt_prev;
    logic [3:0]             flt_cnt [NUM_IN];
    logic [PW-1:0]          prime_cnt;
    logic                   primed;
    logic                   prime_done;

    logic [1:0] phase_now;
    logic [1:0] phase_was;
    logic       step_fwd;
    logic       step_rev;
    logic       phase_jump;
    logic       index_rise;
    logic       live;
    logic       step_take;

    assign raw       = {index, quad_b, quad_a};
    assign set_value = HOME_VALUE;

    genvar g;
    for (g = 0; g < NUM_IN; g++) begin : g_sync
        assign synced[g] = sync_q[g][SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
        end
    end

    // The first window lets the sync chains flush, then adopts the live levels silently.
    assign prime_done = !primed && (prime_cnt == PRIME_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_done) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt      <= '0;
            filt_prev <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            filt_prev <= prime_done ? synced : filt;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!primed) begin
                    flt_cnt[i] <= '0;
                    if (prime_done) begin
                        filt[i] <= synced[i];
                    end
                end else if (synced[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FILTER_LAST) begin
                    filt[i]    <= synced[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Forward Gray order 00->01->11->10: next = {B, ~A}; reverse is the mirror.
    assign phase_now  = {filt[0], filt[1]};
    assign phase_was  = {filt_prev[0], filt_prev[1]};
    assign step_fwd   = (phase_now == {phase_was[0], ~phase_was[1]});
    assign step_rev   = (phase_now == {~phase_was[0], phase_was[1]});
    assign phase_jump = ((phase_now ^ phase_was) == 2'b11);
    assign index_rise = filt[2] & ~filt_prev[2];
    assign live       = dec_en & primed;
    assign step_take  = live & (step_fwd | step_rev) & ~index_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable  <= 1'b0;
            up_down <= 1'b0;
            set     <= 1'b0;
            error   <= 1'b0;
        end else begin
            enable <= step_take;
            set    <= live & index_rise;
            error  <= live & phase_jump;
            if (step_take) begin
                up_down <= step_fwd;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - bench for quad_step_decoder with behavioural model
module tb_quad_step_decoder;
    localparam int         SYNC  = 2;
    localparam int         FLEN  = 3;
    localparam logic [3:0] HOME  = 4'd9;
    localparam int         PRIME = SYNC + FLEN;
    localparam int         DEPTH = 16384;

    logic       clk;
    logic       reset;
    logic       quad_a;
    logic       quad_b;
    logic       index;
    logic       dec_en;
    logic       enable;
    logic       up_down;
    logic       set;
    logic [3:0] set_value;
    logic       error;

    quad_step_decoder #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FLEN),
        .HOME_VALUE (HOME)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .quad_a   (quad_a),
        .quad_b   (quad_b),
        .index    (index),
        .dec_en   (dec_en),
        .enable   (enable),
        .up_down  (up_down),
        .set      (set),
        .set_value(set_value),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic checking = 1'b0;

    logic [2:0] raw_h [DEPTH];
    logic       en_h  [DEPTH];
    logic [2:0] f_h   [DEPTH];
    int   cyc = 0;
    logic exp_en = 1'b0, exp_ud = 1'b0, exp_set = 1'b0, exp_err = 1'b0;

    int cnt_en, cnt_dn, cnt_set, cnt_err, first_en_cyc;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Filtered level: a value is accepted once it has been seen FLEN times in a row at the synchronizer output.
    function automatic logic [2:0] model_filter(input int n);
        logic [2:0] f;
        logic       same;
        int         start;
        if (n < PRIME) return 3'b000;
        if (n == PRIME) return raw_h[PRIME-SYNC];
        f = f_h[n-1];
        start = n - SYNC - FLEN + 1;
        if (start >= PRIME - SYNC + 1) begin
            for (int i = 0; i < 3; i++) begin
                same = 1'b1;
                for (int k = start; k <= n - SYNC; k++) begin
                    if (raw_h[k][i] != raw_h[start][i]) same = 1'b0;
                end
                if (same) f[i] = raw_h[start][i];
            end
        end
        return f;
    endfunction

    always @(posedge clk) begin
        logic [2:0] pv, cv;
        int         d;
        logic       rise;
        if (!reset) begin
            cyc = 0;
            exp_en = 1'b0; exp_ud = 1'b0; exp_set = 1'b0; exp_err = 1'b0;
        end else if (cyc < DEPTH - 1) begin
            cyc = cyc + 1;
            raw_h[cyc] = {index, quad_b, quad_a};
            en_h[cyc]  = dec_en;
            f_h[cyc]   = model_filter(cyc);
            exp_en = 1'b0; exp_set = 1'b0; exp_err = 1'b0;
            if (cyc >= PRIME + 2) begin
                pv   = f_h[cyc-2];
                cv   = f_h[cyc-1];
                d    = (gpos({cv[0], cv[1]}) - gpos({pv[0], pv[1]}) + 4) % 4;
                rise = cv[2] & ~pv[2];
                if (en_h[cyc]) begin
                    exp_set = rise;
                    exp_err = (d == 2);
                    if ((d == 1 || d == 3) && !rise) begin
                        exp_en = 1'b1;
                        exp_ud = (d == 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("enable",    int'(enable),    reset ? int'(exp_en)  : 0);
            check("up_down",   int'(up_down),   reset ? int'(exp_ud)  : 0);
            check("set",       int'(set),       reset ? int'(exp_set) : 0);
            check("error",     int'(error),     reset ? int'(exp_err) : 0);
            check("set_value", int'(set_value), int'(HOME));
            if (enable) begin
                cnt_en++;
                if (!up_down) cnt_dn++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (set)   cnt_set++;
            if (error) cnt_err++;
        end
    end

    task automatic wait_cyc(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        cnt_en = 0; cnt_dn = 0; cnt_set = 0; cnt_err = 0; first_en_cyc = -1;
    endtask

    task automatic set_ab(input logic a, input logic b);
        quad_a = a;
        quad_b = b;
    endtask

    initial begin
        int drive_cyc;
        int found;
        reset = 1'b1; quad_a = 1'b1; quad_b = 1'b1; index = 1'b0; dec_en = 1'b1;
        clear_counts();
        #1 reset = 1'b0;
        checking = 1'b1;
        wait_cyc(4);
        reset = 1'b1;
        clear_counts();
        wait_cyc(30);
        check("prime_no_enable", cnt_en, 0);
        check("prime_no_error", cnt_err, 0);

        set_ab(1'b1, 1'b0); wait_cyc(8);
        set_ab(1'b0, 1'b0); wait_cyc(8);
        check("lead_in_steps", cnt_en, 2);

        clear_counts();
        drive_cyc = cyc;
        set_ab(1'b0, 1'b1); wait_cyc(8);
        set_ab(1'b1, 1'b1); wait_cyc(8);
        set_ab(1'b1, 1'b0); wait_cyc(8);
        set_ab(1'b0, 1'b0); wait_cyc(8);
        check("fwd_count", cnt_en, 4);
        check("fwd_down", cnt_dn, 0);
        check("fwd_error", cnt_err, 0);
        check("fwd_latency", first_en_cyc - drive_cyc, 6);

        clear_counts();
        set_ab(1'b1, 1'b0); wait_cyc(8);
        set_ab(1'b1, 1'b1); wait_cyc(3);
        dec_en = 1'b0;      wait_cyc(3);
        dec_en = 1'b1;      wait_cyc(2);
        set_ab(1'b0, 1'b1); wait_cyc(8);
        set_ab(1'b0, 1'b0); wait_cyc(8);
        check("rev_count", cnt_en, 3);
        check("rev_down", cnt_dn, 3);

        clear_counts();
        quad_a = 1'b1; wait_cyc(2);
        quad_a = 1'b0; wait_cyc(10);
        check("glitch_enable", cnt_en, 0);
        check("glitch_error", cnt_err, 0);

        clear_counts();
        set_ab(1'b1, 1'b1); wait_cyc(8);
        check("jump_error", cnt_err, 1);
        check("jump_enable", cnt_en, 0);
        set_ab(1'b0, 1'b0); wait_cyc(8);

        clear_counts();
        quad_b = 1'b1; index = 1'b1; wait_cyc(8);
        check("index_set", cnt_set, 1);
        check("index_enable", cnt_en, 0);
        index = 1'b0; wait_cyc(8);

        set_ab(1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (enable) found = 1;
        end
        check("mid_pulse_seen", found, 1);
        reset = 1'b0;
        #1;
        check("rst_enable", int'(enable), 0);
        check("rst_up_down", int'(up_down), 0);
        check("rst_set", int'(set), 0);
        check("rst_error", int'(error), 0);
        check("rst_set_value", int'(set_value), int'(HOME));
        wait_cyc(3);
        reset = 1'b1;
        clear_counts();
        wait_cyc(20);
        check("reprime_quiet", cnt_en + cnt_err, 0);
        set_ab(1'b1, 1'b0); wait_cyc(8);
        set_ab(1'b0, 1'b0); wait_cyc(8);
        check("resume_count", cnt_en, 2);
        check("resume_down", cnt_dn, 0);

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                wait_cyc(2);
                reset = 1'b1;
            end
            quad_a = 1'($urandom);
            quad_b = 1'($urandom);
            index  = ($urandom_range(0, 3) == 0);
            dec_en = ($urandom_range(0, 9) != 0);
            wait_cyc($urandom_range(1, 10));
        end
        dec_en = 1'b1;
        wait_cyc(12);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
